// File: rtl/vr_rr_arbiter.sv
// rtl/vr_rr_arbiter.sv - round-robin arbiter feeding one registered valid/ready output stage
module vr_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src,
  output logic [CNT_WIDTH-1:0]          xfer_count
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0]      out_src_q, out_src_d;
  logic [SRC_W-1:0]      last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]  xfer_count_q, xfer_count_d;

  logic can_load;
  logic found;
  logic up_xfer;
  logic dn_xfer;
  int   win_idx;
  int   cand;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    can_load = !out_valid_q || out_ready;
    found    = 1'b0;
    win_idx  = 0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    up_xfer = found && can_load && !rst;
    dn_xfer = out_valid_q && out_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = up_xfer && (win_idx == i);
    end
  end

  // Next state of the output stage, pointer and transfer counter
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    xfer_count_d = xfer_count_q;
    if (dn_xfer) begin
      xfer_count_d = xfer_count_q + CNT_WIDTH'(1);
    end
    // A new word overwrites a departing one in the same edge, so no bubble
    if (up_xfer) begin
      out_valid_d  = 1'b1;
      out_data_d   = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
      out_src_d    = SRC_W'(win_idx);
      last_grant_d = SRC_W'(win_idx);
    end else if (dn_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset puts the pointer on the last requester so index 0 is searched first
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      last_grant_q <= SRC_W'(NUM_REQ - 1);
      xfer_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// tb/tb_vr_rr_arbiter.sv - self-checking bench for vr_rr_arbiter
module tb_vr_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic          out_ready;

  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic [15:0]   xfer_count;

  logic [N-1:0]  c4_req_ready;
  logic          c4_out_valid;
  logic [DW-1:0] c4_out_data;
  logic [1:0]    c4_out_src;
  logic [3:0]    c4_xfer_count;

  always #5 clk = ~clk;

  vr_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .xfer_count(xfer_count)
  );

  vr_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_c4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(c4_req_ready),
    .req_data(req_data), .out_valid(c4_out_valid), .out_ready(out_ready),
    .out_data(c4_out_data), .out_src(c4_out_src), .xfer_count(c4_xfer_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: held word, pointer, unbounded transfer count, per-source scoreboard
  bit         m_valid;
  int         m_data;
  int         m_src;
  int         m_last;
  int         m_cnt;
  logic [7:0] sb[N][$];
  logic [N-1:0] hs;

  function automatic int pick();
    int w;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (w < 0 && req_valid[i]) w = i;
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic check();
    int w;
    bit can_load;
    logic [N-1:0] er;
    @(negedge clk);
    w = pick();
    can_load = !m_valid || out_ready;
    er = '0;
    if (!rst && w >= 0 && can_load) er[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_src", 32'(out_src), 32'(m_src));
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt % 65536));
    chk("xfer_count_c4", 32'(c4_xfer_count), 32'(m_cnt % 16));
    if (!rst && m_valid && out_ready)
      chk("sb_order", 32'(out_data), (sb[m_src].size() > 0) ? 32'(sb[m_src][0]) : 32'hDEAD);
  endtask

  task automatic tick();
    int w;
    bit up, dn;
    w  = pick();
    hs = '0;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_src = 0; m_last = N - 1; m_cnt = 0;
      for (int i = 0; i < N; i++) sb[i].delete();
    end else begin
      up = (w >= 0) && (!m_valid || out_ready);
      dn = m_valid && out_ready;
      if (dn) begin
        m_cnt++;
        if (sb[m_src].size() > 0) void'(sb[m_src].pop_front());
      end
      if (up) begin
        m_data  = int'(req_data[w*DW +: DW]);
        m_src   = w;
        m_valid = 1;
        m_last  = w;
        hs[w]   = 1'b1;
        sb[w].push_back(req_data[w*DW +: DW]);
      end else if (dn) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  initial begin
    int left;
    m_valid = 0; m_data = 0; m_src = 0; m_last = N - 1; m_cnt = 0;
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;

    // reset state
    check(); tick(); check(); tick();
    rst = 1'b0;

    // lone requester 2
    req_valid = 4'b0100; set_data(2, 8'hA5); out_ready = 1'b1;
    check(); chk("t1_ready", 32'(req_ready), 32'h4);
    tick();
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(out_data), 32'hA5);
    chk("t1_src", 32'(out_src), 32'h2);
    req_valid = '0;
    check(); tick();
    chk("t1_count", 32'(xfer_count), 32'h1);

    // fairness with all valid
    rst = 1'b1; check(); tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, 8'(8'h10 + i));
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check(); tick();
      chk("t2_src", 32'(out_src), 32'(k % 4));
      chk("t2_data", 32'(out_data), 32'(8'h10 + k % 4));
      chk("t2_valid", 32'(out_valid), 32'h1);
    end

    // backpressure hold, pointer frozen
    req_valid = 4'b0010; set_data(1, 8'h21);
    check(); tick();
    chk("t3_src1", 32'(out_src), 32'h1);
    req_valid = 4'b1010; set_data(1, 8'h22); set_data(3, 8'h33); out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check(); chk("t3_ready_hold", 32'(req_ready), 32'h0);
      tick();
      chk("t3_data_hold", 32'(out_data), 32'h21);
      chk("t3_src_hold", 32'(out_src), 32'h1);
    end
    out_ready = 1'b1;
    check(); chk("t3_ready3", 32'(req_ready), 32'h8);
    tick();
    chk("t3_src3", 32'(out_src), 32'h3);
    chk("t3_data3", 32'(out_data), 32'h33);
    req_valid = 4'b0010;
    check(); chk("t3_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("t3_data22", 32'(out_data), 32'h22);

    // interleave 0,1,0,0
    req_valid = 4'b0001; set_data(0, 8'h40);
    check(); tick();
    chk("t4_a", 32'({out_src, out_data}), 32'({2'd0, 8'h40}));
    req_valid = 4'b0011; set_data(0, 8'h41); set_data(1, 8'h50);
    check(); tick();
    chk("t4_b", 32'({out_src, out_data}), 32'({2'd1, 8'h50}));
    req_valid = 4'b0001;
    check(); tick();
    chk("t4_c", 32'({out_src, out_data}), 32'({2'd0, 8'h41}));
    set_data(0, 8'h42);
    check(); tick();
    chk("t4_d", 32'({out_src, out_data}), 32'({2'd0, 8'h42}));

    // reset while holding a stalled word
    req_valid = 4'b0100; set_data(2, 8'h77);
    check(); tick();
    req_valid = 4'b1010; out_ready = 1'b0;
    check(); tick();
    chk("t5_held", 32'(out_valid), 32'h1);
    rst = 1'b1;
    check(); tick();
    rst = 1'b0;
    chk("t5_valid", 32'(out_valid), 32'h0);
    chk("t5_count", 32'(xfer_count), 32'h0);
    check(); chk("t5_first_grant", 32'(req_ready), 32'h2);
    tick();

    // counter wrap on the 4-bit instance
    rst = 1'b1; check(); tick(); rst = 1'b0;
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      check(); tick();
    end
    chk("t6_wrap_c4", 32'(c4_xfer_count), 32'h1);
    chk("t6_count16", 32'(xfer_count), 32'd17);

    // randomized traffic with held valid/data until handshake
    rst = 1'b1; check(); tick(); rst = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || hs[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_data(i, 8'($urandom));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      check(); tick();
    end

    // drain and confirm nothing was lost
    req_valid = '0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check(); tick();
    end
    left = 0;
    for (int i = 0; i < N; i++) left += sb[i].size();
    chk("drain_empty", 32'(left), 32'h0);
    chk("drain_valid", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
